// File: rtl/mine_placer.sv
// Builds a fresh mine map for a new game: NUM_MINES distinct mines drawn from a
// free-running LFSR, never on the latched first-click tile.
module mine_placer #(
  parameter int          NUM_SQUARES  = 5,
  parameter int          INDEX_LENGTH = $clog2(NUM_SQUARES**2),
  parameter int          NUM_MINES    = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [INDEX_LENGTH-1:0]          safe_index,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_SQUARES**2-1:0]        mine_map,
  output logic [$clog2(NUM_MINES+1)-1:0]   mines_placed
);

  localparam int                    TILES   = NUM_SQUARES**2;
  localparam int                    CNT_W   = $clog2(NUM_MINES+1);
  localparam int                    EXT_W   = 2**INDEX_LENGTH;
  localparam logic [15:0]           TAPS    = 16'hB400;
  localparam logic [INDEX_LENGTH:0] TILES_W = (INDEX_LENGTH+1)'(TILES);
  localparam logic [CNT_W-1:0]      LAST    = CNT_W'(NUM_MINES-1);

  generate
    if (NUM_MINES < 1 || NUM_MINES > TILES-1) begin : g_bad_mines
      $error("mine_placer: NUM_MINES must be in 1..NUM_SQUARES**2-1");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("mine_placer: LFSR_SEED must be nonzero");
    end
  endgenerate

  typedef enum logic {IDLE, DRAW} state_t;

  state_t                  state, state_next;
  logic [15:0]             lfsr;
  logic [INDEX_LENGTH-1:0] safe_q;
  logic [INDEX_LENGTH-1:0] candidate;
  logic [EXT_W-1:0]        map_ext;
  logic [EXT_W-1:0]        map_set;
  logic                    load;
  logic                    accept;
  logic                    finish;

  assign candidate = lfsr[INDEX_LENGTH-1:0];
  assign busy      = (state == DRAW);

  // Widen the map to the full index range so out-of-board candidates read as 0.
  always_comb begin
    map_ext             = '0;
    map_ext[TILES-1:0]  = mine_map;
    map_set             = map_ext | (EXT_W'(1) << candidate);
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (({1'b0, candidate} < TILES_W) && (candidate != safe_q) &&
            !map_ext[candidate]) begin
          accept = 1'b1;
          if (mines_placed == LAST) begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Galois LFSR runs in every state so the layout depends on the start time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      safe_q       <= '0;
      mine_map     <= '0;
      mines_placed <= '0;
      done         <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        safe_q       <= safe_index;
        mine_map     <= '0;
        mines_placed <= '0;
      end else if (accept) begin
        mine_map     <= map_set[TILES-1:0];
        mines_placed <= mines_placed + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Randomised bench for mine_placer: a behavioural board model is compared every
// cycle, with literal expectations pinning the LFSR and the full-board case.
module tb_mine_placer;

  localparam int          TILES = 25;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  safe_index = '0;
  logic        busy, done;
  logic [24:0] mine_map;
  logic [2:0]  mines_placed;

  logic        start24 = 1'b0;
  logic [4:0]  safe24 = '0;
  logic        busy24, done24;
  logic [24:0] map24;
  logic [4:0]  mines24;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mine_placer dut (
    .clk(clk), .rst(rst), .start(start), .safe_index(safe_index),
    .busy(busy), .done(done), .mine_map(mine_map), .mines_placed(mines_placed)
  );

  mine_placer #(.NUM_MINES(24)) dut24 (
    .clk(clk), .rst(rst), .start(start24), .safe_index(safe24),
    .busy(busy24), .done(done24), .mine_map(map24), .mines_placed(mines24)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Behavioural board model: integer tile indices and a plain bit array.
  logic [15:0] m_lfsr = SEED;
  bit          m_draw = 0;
  bit          m_done = 0;
  bit [24:0]   m_map  = '0;
  int          m_cnt  = 0;
  int          m_safe = 0;

  always @(posedge clk or posedge rst) begin
    int cand;
    if (rst) begin
      m_lfsr = SEED; m_draw = 0; m_done = 0; m_map = '0; m_cnt = 0; m_safe = 0;
    end else begin
      cand   = int'(m_lfsr) % 32;
      m_done = 0;
      if (!m_draw) begin
        if (start) begin
          m_draw = 1; m_map = '0; m_cnt = 0; m_safe = int'(safe_index);
        end
      end else if (cand < TILES && cand != m_safe && !m_map[cand]) begin
        m_map[cand] = 1'b1;
        m_cnt++;
        if (m_cnt == 5) begin
          m_draw = 0;
          m_done = 1;
        end
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy", busy, m_draw);
      chk("done", done, m_done);
      chk("mine_map", mine_map, m_map);
      chk("mines_placed", mines_placed, m_cnt);
      chk("popcount_inv", $countones(mine_map), mines_placed);
      chk("popcount24_inv", $countones(map24), mines24);
      if (done) begin
        chk("done_count", $countones(mine_map), 5);
        if (m_safe < TILES) chk("safe_clear", mine_map[m_safe], 0);
      end
    end
  end

  task automatic wait_done(input int bound, input bit noise, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        start = 1'b0;
        ok = 1;
        break;
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) safe_index = 5'($urandom_range(0, 31));
    end
    if (!ok) begin
      start = 1'b0;
      chk("done_timeout", 0, 1);
    end
  endtask

  task automatic pulse_start(input logic [4:0] s);
    start = 1'b1;
    safe_index = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_from_reset(input int n, input logic [4:0] s, output logic [24:0] map);
    bit ok;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    pulse_start(s);
    wait_done(2000, 0, ok);
    map = mine_map;
  endtask

  initial begin
    logic [15:0] v;
    logic [24:0] map_a, map_b;
    bit ok;

    v = lfsr_step(SEED);
    chk("lfsr_pin1", v, 16'hE270);
    for (int i = 0; i < 5; i++) v = lfsr_step(v);
    chk("lfsr_pin6", v, 16'hB313);

    // Reset and idle hold
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_map", mine_map, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", mines_placed, 0);
    repeat (20) @(negedge clk);
    chk("idle_map", mine_map, 0);

    // Default run, safe tile 12
    repeat (6) @(negedge clk);
    pulse_start(5'd12);
    wait_done(2000, 0, ok);
    map_a = mine_map;
    chk("run_pop", $countones(map_a), 5);
    chk("run_safe12", map_a[12], 0);
    chk("run_cnt", mines_placed, 5);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // Full board but the safe tile
    start24 = 1'b1;
    safe24  = 5'd0;
    @(negedge clk);
    start24 = 1'b0;
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done24) begin
        ok = 1;
        break;
      end
    end
    chk("full_done_seen", ok, 1);
    chk("full_map", map24, 25'h1FFFFFE);
    chk("full_cnt", mines24, 24);

    // Extra starts while busy, then restart in the done cycle
    pulse_start(5'd3);
    for (int i = 0; i < 3 && busy && !done; i++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(2000, 0, ok);
    start = 1'b1;
    safe_index = 5'd7;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", busy, 1);
    wait_done(2000, 0, ok);

    // Reset in the middle of a draw
    @(negedge clk);
    pulse_start(5'd20);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_map", mine_map, 0);
    chk("async_cnt", mines_placed, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_done_after_rst", done, 0);
    pulse_start(5'd20);
    wait_done(2000, 0, ok);
    chk("post_rst_cnt", mines_placed, 5);

    // Same start delay after reset gives the same layout
    run_from_reset(26, 5'd12, map_b);
    chk("repeat_map", map_b, map_a);
    run_from_reset(26, 5'd12, map_b);
    chk("repeat_map2", map_b, map_a);

    // Random start delays, safe tiles, busy noise and mid-run resets
    for (int r = 0; r < 1000; r++) begin
      int mode;
      repeat ($urandom_range(0, 15)) @(negedge clk);
      pulse_start(5'($urandom_range(0, 31)));
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end else begin
        wait_done(2000, mode < 4, ok);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
